// File: rtl/mux_sel_scheduler.sv
// Round-robin scheduler that drives the two select lines of a 3:1 mux built from 2:1 stages.
// One channel is granted at a time for DWELL cycles; all outputs are registered.
module mux_sel_scheduler #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic       sel0,
    output logic       sel1,
    output logic [2:0] grant,
    output logic       valid,
    output logic       done
);

    localparam logic [7:0] CntLoad = 8'(DWELL - 1);

    typedef enum logic [0:0] {StIdle, StHold} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;
    logic [1:0] cur_q, cur_d;
    logic       arb;
    logic       hold_d;
    logic [2:0] grant_d;
    logic       sel0_d, sel1_d, valid_d, done_d;

    // First requester after 'from' in the cyclic order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [2:0] r);
        logic [1:0] c1, c2, c3;
        case (from)
            2'd0:    begin c1 = 2'd1; c2 = 2'd2; c3 = 2'd0; end
            2'd1:    begin c1 = 2'd2; c2 = 2'd0; c3 = 2'd1; end
            default: begin c1 = 2'd0; c2 = 2'd1; c3 = 2'd2; end
        endcase
        if (r[c1]) return c1;
        if (r[c2]) return c2;
        return c3;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cur_d   = cur_q;
        arb     = 1'b0;

        if (state_q == StHold) begin
            // Early release (requester gone) and dwell end both hand over to arbitration.
            if ((grant & req) == 3'b000 || cnt_q == 8'd0) begin
                last_d = cur_q;
                arb    = 1'b1;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end else begin
            arb = 1'b1;
        end

        if (arb) begin
            if (en && req != 3'b000) begin
                cur_d   = rr_pick(last_d, req);
                cnt_d   = CntLoad;
                state_d = StHold;
            end else begin
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
        end

        hold_d  = (state_d == StHold);
        grant_d = hold_d ? (3'b001 << cur_d) : 3'b000;
        sel0_d  = hold_d && (cur_d == 2'd2);
        sel1_d  = hold_d && (cur_d == 2'd1);
        valid_d = hold_d;
        // done marks the final cycle of a dwell, so it rises as the counter lands on zero.
        done_d  = hold_d && (cnt_d == 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            last_q  <= 2'd2;
            cur_q   <= 2'd0;
            grant   <= 3'b000;
            sel0    <= 1'b0;
            sel1    <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            grant   <= grant_d;
            sel0    <= sel0_d;
            sel1    <= sel1_d;
            valid   <= valid_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Bench for mux_sel_scheduler: three instances (DWELL 4, 2, 1) share stimulus and are
// compared each cycle against a channel/remaining-cycles reference model.
module tb_mux_sel_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] req = 3'b000;

    logic       sel0_v [3];
    logic       sel1_v [3];
    logic [2:0] grant_v[3];
    logic       valid_v[3];
    logic       done_v [3];

    int checks   = 0;
    int failures = 0;

    int dw    [3] = '{4, 2, 1};
    int m_ch  [3];
    int m_rem [3];
    int m_last[3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mux_sel_scheduler #(
            .DWELL(gi == 0 ? 4 : (gi == 1 ? 2 : 1))
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .req  (req),
            .sel0 (sel0_v[gi]),
            .sel1 (sel1_v[gi]),
            .grant(grant_v[gi]),
            .valid(valid_v[gi]),
            .done (done_v[gi])
        );
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ch[i]   = -1;
            m_rem[i]  = 0;
            m_last[i] = 2;
        end
    endtask

    task automatic model_step(input int i);
        bit rearb = 1'b0;
        if (m_ch[i] >= 0) begin
            if (!req[m_ch[i]] || m_rem[i] == 1) begin
                m_last[i] = m_ch[i];
                rearb = 1'b1;
            end else begin
                m_rem[i] = m_rem[i] - 1;
            end
        end else begin
            rearb = 1'b1;
        end
        if (rearb) begin
            m_ch[i] = -1;
            if (en && req != 3'b000) begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last[i] + k) % 3;
                    if (m_ch[i] < 0 && req[c]) begin
                        m_ch[i]  = c;
                        m_rem[i] = dw[i];
                    end
                end
            end
        end
    endtask

    // {sel0, sel1, grant, valid, done}
    function automatic logic [6:0] expect_vec(input int i);
        logic [2:0] g;
        logic       act;
        act = (m_ch[i] >= 0);
        g   = act ? 3'(1 << m_ch[i]) : 3'b000;
        return {m_ch[i] == 2, m_ch[i] == 1, g, act, act && m_rem[i] == 1};
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            logic [6:0] obs;
            logic       ok;
            obs = {sel0_v[i], sel1_v[i], grant_v[i], valid_v[i], done_v[i]};
            check($sformatf("%s_dw%0d", tag, dw[i]), {1'b0, obs}, {1'b0, expect_vec(i)});
            ok = !(sel0_v[i] && sel1_v[i]) && (valid_v[i] == |grant_v[i])
                 && ($countones(grant_v[i]) <= 1);
            check($sformatf("%s_inv_dw%0d", tag, dw[i]), {7'b0, ok}, 8'd1);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
        #1;
        check_all(tag);
    endtask

    // Pulses reset between edges; call right after tick().
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all(tag);
        #1 rst = 1'b0;
    endtask

    logic [2:0] rr_grant[7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        req = 3'b001;
        en  = 1'b1;

        // Single request, DWELL=4: ch0 held 4 cycles, done on the 4th, then re-granted.
        for (int t = 1; t <= 8; t++) begin
            tick("single");
            check("single_grant", {5'b0, grant_v[0]}, 8'b001);
            check("single_done", {7'b0, done_v[0]}, {7'b0, (t == 4 || t == 8)});
        end

        // Round-robin, DWELL=2, all requesting.
        async_reset("rr_rst");
        req = 3'b111;
        for (int t = 0; t < 7; t++) begin
            tick("rr");
            check("rr_grant", {5'b0, grant_v[1]}, {5'b0, rr_grant[t]});
            check("rr_done", {7'b0, done_v[1]}, {7'b0, t[0]});
        end

        // Early release of ch1 hands straight over to ch2.
        async_reset("er_rst");
        req = 3'b010;
        tick("er");
        tick("er");
        req = 3'b100;
        tick("er");
        check("er_grant", {5'b0, grant_v[0]}, 8'b100);
        check("er_sel0", {7'b0, sel0_v[0]}, 8'd1);
        check("er_done", {7'b0, done_v[0]}, 8'd0);
        tick("er");

        // Enable drop mid-dwell: dwell completes, then idle, then resume after ch0.
        async_reset("en_rst");
        req = 3'b111;
        tick("en");
        tick("en");
        en = 1'b0;
        tick("en");
        tick("en");
        check("en_done", {7'b0, done_v[0]}, 8'd1);
        tick("en");
        check("en_idle", {5'b0, grant_v[0]}, 8'b000);
        en = 1'b1;
        tick("en");
        check("en_resume", {5'b0, grant_v[0]}, 8'b010);

        // Async reset while ch2 is mid-dwell.
        async_reset("ar_rst0");
        req = 3'b100;
        tick("ar");
        tick("ar");
        check("ar_pre", {7'b0, sel0_v[0]}, 8'd1);
        async_reset("ar_rst");
        check("ar_grant0", {5'b0, grant_v[0]}, 8'b000);
        req = 3'b111;
        tick("ar");
        check("ar_first", {5'b0, grant_v[0]}, 8'b001);

        // DWELL=1 with two requesters alternates every cycle.
        async_reset("d1_rst");
        req = 3'b101;
        for (int t = 0; t < 6; t++) begin
            tick("d1");
            check("d1_grant", {5'b0, grant_v[2]}, t[0] ? 8'b100 : 8'b001);
            check("d1_done", {7'b0, done_v[2]}, 8'd1);
        end

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            req = 3'($urandom);
            en  = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) != 0 && n > 0) req = req | 3'($urandom_range(0, 7));
            tick("rand");
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_sel_scheduler.md
# mux_sel_scheduler

Round-robin select-line scheduler that drives the `sel0`/`sel1` inputs of the 3:1 channel mux, which is built from two 2:1 stages. Three channels raise requests. The block grants one channel at a time for a fixed dwell of DWELL cycles and encodes the grant onto the two select lines the mux expects. It sits directly upstream of the mux and owns all select sequencing, so the mux itself stays purely combinational.

## Interface
- DWELL, 4, cycles each grant is held; legal range 1..255; 8-bit internal counter.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scheduling enable; when low, no new grant is issued.
- req  input  3  per-channel request; bit n = channel n (mux input in).
- sel0  output  1  mux select, outer stage; 1 selects channel 2.
- sel1  output  1  mux select, inner stage; 1 selects channel 1 when sel0=0.
- grant  output  3  one-hot current grant; 000 when idle.
- valid  output  1  high while any grant is active.
- done  output  1  one-cycle pulse when a grant completes its full DWELL.

## Operation
- Select encoding:
  - ch0 → sel0=0, sel1=0.
  - ch1 → sel0=0, sel1=1.
  - ch2 → sel0=1, sel1=0 (sel1 forced 0).
  - Idle → sel0=0, sel1=0.
- Pointer `last` (2 bits) records the most recently granted channel. Priority search order is last+1, last+2, last+3 (mod 3).
- Two-state FSM:
  - IDLE: if en=1 and req≠000, grant the first requester in round-robin order and load cnt=DWELL-1, then go to HOLD. Otherwise stay in IDLE with grant=000 and valid=0.
  - HOLD, early release: if the granted channel's req bit is 0, the grant ends this cycle with no done pulse. Re-arbitrate in the same cycle as from IDLE (the released channel becomes `last`).
  - HOLD, dwell end: else if cnt==0, assert done for one cycle and update `last`. Then, if en=1 and req≠000, issue the next round-robin grant back-to-back with no idle cycle and reload cnt. Otherwise go to IDLE.
  - HOLD, otherwise: decrement cnt and keep grant and selects unchanged.
- A grant is non-preemptive: higher-order requests arriving mid-dwell wait for the dwell to end.
- en=0 during HOLD does not truncate the current dwell. When that dwell ends the FSM goes to IDLE, and done still pulses.
- Back-to-back re-grant may pick the same channel only if it is the sole requester.
- DWELL=1: every grant lasts exactly one cycle, and done pulses every cycle while requests persist.
- Invariants:
  - grant is always one-hot or 000.
  - sel0 and sel1 are never both 1.
  - valid equals OR(grant).

## Timing
- All outputs are registered. Reset values: sel0=0, sel1=0, grant=000, valid=0, done=0, cnt=0, last=2 (so ch0 wins first), state=IDLE.
- Reset is asynchronous. Asserting rst mid-HOLD clears all outputs immediately, with no done pulse. The first grant after reset release comes one edge after req is sampled.
- Latency from req sampled high in IDLE to grant, sel and valid is 1 clock.
- A full grant holds its outputs for exactly DWELL cycles.
- done is high on the last cycle of the dwell, coincident with the final cycle of that grant.
- Early release: outputs change on the edge after req drops (1 cycle).
- sel0 and sel1 change only on clock edges and are glitch-free to the mux.

## Test plan
- Reset and single request: with DWELL=4, assert rst, then release it with req=001, en=1. Required response:
  - One edge later, grant=001, sel0=0, sel1=0 and valid=1 for 4 cycles.
  - done pulses in cycle 4.
  - Then, with req still 001, ch0 is re-granted back-to-back.
- Round-robin fairness: with DWELL=2 and req=111 held, the grant sequence must be 001, 010, 100, 001. Selects follow (0,0), (0,1), (1,0), (0,0), and done pulses every 2nd cycle.
- Early release: with DWELL=4 and req=010 granted, drop req[1] in cycle 2. Required response:
  - The grant ends the next edge with no done pulse.
  - If req[2]=1, grant=100 and sel0=1 follow immediately.
- Enable drop: with DWELL=4 and req=111, take en low mid-dwell. Required response:
  - The current dwell completes and done pulses.
  - The FSM then returns to IDLE with grant=000 and sel=00.
  - With en high again, arbitration resumes from `last`+1.
- Async reset mid-HOLD: with ch2 granted (sel0=1) and cnt=2, assert rst between edges. All outputs must go to 0 immediately; the next grant after release goes to ch0.
- DWELL=1: with req=101, grants must alternate 001 and 100 every cycle, done must stay high continuously, and sel0/sel1 must never be 11.
